// File: rtl/lc3_execute_stage.sv
// LC3 execute stage: ALU (ADD/AND/NOT) and PC-relative address generation.
// Results, destination and writeback control are registered for the writeback stage.
module lc3_execute_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable_execute,
    input  logic [DW-1:0] IR,
    input  logic [DW-1:0] npc_in,
    input  logic [5:0]    E_Control,
    input  logic [1:0]    W_Control_in,
    input  logic [DW-1:0] VSR1,
    input  logic [DW-1:0] VSR2,
    output logic [RW-1:0] sr1,
    output logic [RW-1:0] sr2,
    output logic [DW-1:0] aluout,
    output logic [DW-1:0] pcout,
    output logic [RW-1:0] dr,
    output logic [1:0]    W_Control_out,
    output logic [DW-1:0] IR_Exec,
    output logic          valid_out
);

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;

    localparam logic [1:0] OFF_11   = 2'b00;
    localparam logic [1:0] OFF_9    = 2'b01;
    localparam logic [1:0] OFF_6    = 2'b10;

    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;

    assign alu_control = E_Control[5:4];
    assign pcselect1   = E_Control[3:2];
    assign pcselect2   = E_Control[1];
    assign op2select   = E_Control[0];

    // Register-file read addresses come straight from the incoming IR.
    assign sr1 = IR[8:6];
    assign sr2 = IR[2:0];

    // Sign-extended immediate fields; each bit above the field's MSB copies that MSB.
    logic [DW-1:0] imm5_sext;
    logic [DW-1:0] off6_sext;
    logic [DW-1:0] off9_sext;
    logic [DW-1:0] off11_sext;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_sext
            assign imm5_sext[gi]  = IR[(gi < 5)  ? gi : 4];
            assign off6_sext[gi]  = IR[(gi < 6)  ? gi : 5];
            assign off9_sext[gi]  = IR[(gi < 9)  ? gi : 8];
            assign off11_sext[gi] = IR[(gi < 11) ? gi : 10];
        end
    endgenerate

    logic [DW-1:0] op2;
    logic [DW-1:0] alu_next;
    logic [DW-1:0] offset;
    logic [DW-1:0] base;
    logic [DW-1:0] pc_next;

    assign op2 = op2select ? VSR2 : imm5_sext;

    always_comb begin
        alu_next = VSR1;
        case (alu_control)
            ALU_ADD: alu_next = VSR1 + op2;
            ALU_AND: alu_next = VSR1 & op2;
            ALU_NOT: alu_next = ~VSR1;
            default: alu_next = VSR1;
        endcase
    end

    always_comb begin
        offset = '0;
        case (pcselect1)
            OFF_11:  offset = off11_sext;
            OFF_9:   offset = off9_sext;
            OFF_6:   offset = off6_sext;
            default: offset = '0;
        endcase
    end

    assign base    = pcselect2 ? npc_in : VSR1;
    assign pc_next = base + offset;

    logic [DW-1:0] aluout_reg;
    logic [DW-1:0] pcout_reg;
    logic [RW-1:0] dr_reg;
    logic [1:0]    w_control_reg;
    logic [DW-1:0] ir_exec_reg;
    logic          valid_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            aluout_reg    <= '0;
            pcout_reg     <= '0;
            dr_reg        <= '0;
            w_control_reg <= '0;
            ir_exec_reg   <= '0;
            valid_reg     <= 1'b0;
        end else if (enable_execute) begin
            aluout_reg    <= alu_next;
            pcout_reg     <= pc_next;
            dr_reg        <= IR[11:9];
            w_control_reg <= W_Control_in;
            ir_exec_reg   <= IR;
            valid_reg     <= 1'b1;
        end
    end

    assign aluout        = aluout_reg;
    assign pcout         = pcout_reg;
    assign dr            = dr_reg;
    assign W_Control_out = w_control_reg;
    assign IR_Exec       = ir_exec_reg;
    assign valid_out     = valid_reg;

endmodule

// File: doc/lc3_execute_stage.md
Name: lc3_execute_stage

Overview:
Execute stage of the LC3 pipeline; it consumes the decode stage's control words.
- Registers IR, NPC, E_Control and W_Control from decode, plus the register-file operands VSR1 and VSR2.
- Performs the ALU operation (ADD/AND/NOT) and the PC-relative address computation (LEA and branch-style targets).
- Presents registered results, destination register and the forwarded W_Control to the writeback stage.

Parameters:
- DW, 16, datapath width (IR, NPC, operands, results)
- RW, 3, register-index width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable_execute  in  1  stage advance strobe from controller
- IR  in  16  instruction from decode
- npc_in  in  16  next PC from decode
- E_Control  in  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
- W_Control_in  in  2  writeback select from decode
- VSR1  in  16  register-file read data for sr1
- VSR2  in  16  register-file read data for sr2
- sr1  out  3  IR[8:6], combinational, drives register-file read port 1
- sr2  out  3  IR[2:0], combinational, drives register-file read port 2
- aluout  out  16  registered ALU result
- pcout  out  16  registered address result
- dr  out  3  registered destination, IR[11:9]
- W_Control_out  out  2  registered pass-through of W_Control_in
- IR_Exec  out  16  registered copy of IR
- valid_out  out  1  high when the registered outputs hold a result computed since reset

Behaviour:
Reset:
- reset=1 at a rising edge clears aluout, pcout, dr, W_Control_out, IR_Exec and valid_out to 0.
- Reset has priority over enable_execute.
- Reset asserted mid-stream discards the in-flight result; outputs read 0 on the next cycle.

Capture and hold:
- When enable_execute=1 and reset=0, all registered outputs load on the rising edge; valid_out is set to 1.
- Latency is 1 cycle from inputs to outputs.
- When enable_execute=0, every registered output holds its value; valid_out holds.
- Back-to-back enables produce one result per cycle.

Operand 2:
- op2select=1: op2 = VSR2.
- op2select=0: op2 = sign-extended IR[4:0] (imm5).

ALU (alu_control):
- 00: VSR1 + op2, modulo 2^16; carry discarded; no overflow flag.
- 01: VSR1 AND op2.
- 10: NOT VSR1; op2 ignored.
- 11 (unused): VSR1 passed unchanged.

Address offset (pcselect1):
- 00: sext IR[10:0]
- 01: sext IR[8:0]
- 10: sext IR[5:0]
- 11: 0

Address base and sum:
- pcselect2=1: base = npc_in; pcselect2=0: base = VSR1.
- pcout = base + offset, modulo 2^16; wrap-around is allowed (0xFFFF + 1 = 0x0000).

Always-computed outputs:
- aluout and pcout are both computed for every instruction regardless of opcode; writeback selects between them via W_Control.
- dr = IR[11:9]. W_Control_out copies W_Control_in unmodified, including any undefined encoding.
- sr1 and sr2 are purely combinational from the current IR input. They do not depend on enable_execute or reset.

Test Plan:
- Reset, then IR=0x1042, E_Control=000001, VSR1=0x0005, VSR2=0x0003, W_Control_in=00, enable=1 -> next cycle aluout=0x0008, dr=0, W_Control_out=00, valid_out=1; sr1=1 and sr2=2 in the same cycle.
- ADD immediate: IR=0x127F (imm5=-1), E_Control=000000, VSR1=0x0000 -> aluout=0xFFFF, dr=1. Repeat with VSR1=0x7FFF and IR=0x1261 -> aluout=0x8000 (wrap, no flag).
- AND immediate: IR=0x5A6F, E_Control=010000, VSR1=0x1234 -> aluout=0x0004. NOT: IR=0x907F, E_Control=100000, VSR1=0x00FF -> aluout=0xFF00.
- LEA: IR=0xE1FF, E_Control=000110, npc_in=0x3001, W_Control_in=10 -> pcout=0x3000, dr=0, W_Control_out=10. Also npc_in=0xFFFF with IR=0xE001 -> pcout=0x0000.
- Hold: after a valid result, drop enable_execute for 3 cycles while changing IR/VSR1/VSR2 -> aluout, pcout, dr, IR_Exec and valid_out unchanged; sr1 and sr2 track the new IR.
- Reset mid-stream: enable=1 and reset=1 in the same cycle -> all registered outputs 0 and valid_out=0 next cycle. Deassert reset with enable=1 -> a new result appears 1 cycle later.
